wb_state_regs: RTL and testbench

WB_STATE_REGS -- requirements
Module: wb_state_regs

---
 rtl/wb_state_regs.sv | 87 ++++++++
 tb/tb_wb_state_regs.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_state_regs.sv
// Write-back architectural state: HI/LO, LLbit and a retired-write counter,
// with same-cycle bypass so EX/MEM always see the newest committed values.
module wb_state_regs (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] wb_hi_i,
  input  logic [31:0] wb_lo_i,
  input  logic        wb_en_hilo_i,
  input  logic        wb_LLbit_en,
  input  logic        wb_LLbit_data,
  input  logic        wb_en_wb,
  input  logic [31:0] mem_hi_i,
  input  logic [31:0] mem_lo_i,
  input  logic        mem_en_hilo_i,
  input  logic        flush,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        LLbit_o,
  output logic [31:0] retire_cnt
);

  localparam int DataWidth = 32;

  logic [DataWidth-1:0] hi_reg, hi_next;
  logic [DataWidth-1:0] lo_reg, lo_next;
  logic                 llbit_reg, llbit_next;
  logic [DataWidth-1:0] retire_cnt_reg, retire_cnt_next;

  // A flush kills the LL/SC reservation but never a HI/LO commit.
  always_comb begin
    hi_next         = hi_reg;
    lo_next         = lo_reg;
    llbit_next      = llbit_reg;
    retire_cnt_next = retire_cnt_reg;
    if (wb_en_hilo_i) begin
      hi_next = wb_hi_i;
      lo_next = wb_lo_i;
    end
    if (flush) begin
      llbit_next = 1'b0;
    end else if (wb_LLbit_en) begin
      llbit_next = wb_LLbit_data;
    end
    if (wb_en_wb && !flush) begin
      retire_cnt_next = retire_cnt_reg + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_reg         <= '0;
      lo_reg         <= '0;
      llbit_reg      <= 1'b0;
      retire_cnt_reg <= '0;
    end else begin
      hi_reg         <= hi_next;
      lo_reg         <= lo_next;
      llbit_reg      <= llbit_next;
      retire_cnt_reg <= retire_cnt_next;
    end
  end

  // HI and LO always come from one source so a pair is never torn.
  always_comb begin
    hi_o = hi_reg;
    lo_o = lo_reg;
    if (mem_en_hilo_i) begin
      hi_o = mem_hi_i;
      lo_o = mem_lo_i;
    end else if (wb_en_hilo_i) begin
      hi_o = wb_hi_i;
      lo_o = wb_lo_i;
    end
  end

  always_comb begin
    LLbit_o = llbit_reg;
    if (flush) begin
      LLbit_o = 1'b0;
    end else if (wb_LLbit_en) begin
      LLbit_o = wb_LLbit_data;
    end
  end

  assign retire_cnt = retire_cnt_reg;

endmodule

// File: tb/tb_wb_state_regs.sv
// Bench for wb_state_regs: directed corner cases plus randomized traffic
// checked against a behavioural model of the architectural state.
module tb_wb_state_regs;

  logic        clk;
  logic        rst_n;
  logic [31:0] wb_hi_i, wb_lo_i, mem_hi_i, mem_lo_i;
  logic        wb_en_hilo_i, wb_LLbit_en, wb_LLbit_data, wb_en_wb;
  logic        mem_en_hilo_i, flush;
  logic [31:0] hi_o, lo_o, retire_cnt;
  logic        LLbit_o;

  int errors = 0;
  int checks = 0;

  wb_state_regs dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .wb_hi_i       (wb_hi_i),
    .wb_lo_i       (wb_lo_i),
    .wb_en_hilo_i  (wb_en_hilo_i),
    .wb_LLbit_en   (wb_LLbit_en),
    .wb_LLbit_data (wb_LLbit_data),
    .wb_en_wb      (wb_en_wb),
    .mem_hi_i      (mem_hi_i),
    .mem_lo_i      (mem_lo_i),
    .mem_en_hilo_i (mem_en_hilo_i),
    .flush         (flush),
    .hi_o          (hi_o),
    .lo_o          (lo_o),
    .LLbit_o       (LLbit_o),
    .retire_cnt    (retire_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    wb_hi_i = '0; wb_lo_i = '0; mem_hi_i = '0; mem_lo_i = '0;
    wb_en_hilo_i = 0; wb_LLbit_en = 0; wb_LLbit_data = 0; wb_en_wb = 0;
    mem_en_hilo_i = 0; flush = 0;
  endtask

  // Advance one full cycle, returning to the falling edge where inputs change.
  task automatic next_cycle();
    @(negedge clk);
  endtask

  // Architectural state as the programmer sees it.
  logic [31:0] m_hi, m_lo, m_cnt;
  logic        m_ll;

  initial begin
    logic [31:0] e_hi, e_lo;
    logic        e_ll;

    idle_inputs();
    rst_n = 1'b0;
    #1;
    check("reset_hi", hi_o, 32'h0);
    check("reset_lo", lo_o, 32'h0);
    check("reset_ll", {31'b0, LLbit_o}, 32'h0);
    check("reset_cnt", retire_cnt, 32'h0);

    @(negedge clk);
    rst_n = 1'b1;

    // Same-cycle bypass, then persistence from the register.
    wb_en_hilo_i = 1; wb_hi_i = 32'h1234; wb_lo_i = 32'h5678;
    #1;
    $display("txn wb hilo commit 0x1234/0x5678");
    check("bypass_hi", hi_o, 32'h1234);
    check("bypass_lo", lo_o, 32'h5678);
    next_cycle();
    idle_inputs();
    #1;
    check("persist_hi", hi_o, 32'h1234);
    check("persist_lo", lo_o, 32'h5678);

    // MEM has priority over WB; WB value lands in the register.
    wb_en_hilo_i = 1; wb_hi_i = 32'h1; wb_lo_i = 32'h11;
    next_cycle();
    wb_en_hilo_i = 1; wb_hi_i = 32'h2; wb_lo_i = 32'h22;
    mem_en_hilo_i = 1; mem_hi_i = 32'h3; mem_lo_i = 32'h33;
    #1;
    $display("txn mem/wb priority");
    check("prio_hi", hi_o, 32'h3);
    check("prio_lo", lo_o, 32'h33);
    next_cycle();
    idle_inputs();
    #1;
    check("after_prio_hi", hi_o, 32'h2);
    check("after_prio_lo", lo_o, 32'h22);

    // LLbit set, then killed by flush despite a concurrent set.
    wb_LLbit_en = 1; wb_LLbit_data = 1;
    next_cycle();
    idle_inputs();
    #1;
    check("ll_set", {31'b0, LLbit_o}, 32'h1);
    flush = 1; wb_LLbit_en = 1; wb_LLbit_data = 1;
    wb_en_hilo_i = 1; wb_hi_i = 32'h77; wb_lo_i = 32'h88;
    #1;
    $display("txn flush with llbit set and hilo write");
    check("ll_flush_comb", {31'b0, LLbit_o}, 32'h0);
    next_cycle();
    idle_inputs();
    #1;
    check("ll_flush_reg", {31'b0, LLbit_o}, 32'h0);
    check("flush_hi_commit", hi_o, 32'h77);
    check("flush_lo_commit", lo_o, 32'h88);

    // Counter wrap from a preloaded value.
    force dut.retire_cnt_reg = 32'hFFFF_FFFE;
    #1;
    release dut.retire_cnt_reg;
    #1;
    check("cnt_preload", retire_cnt, 32'hFFFF_FFFE);
    wb_en_wb = 1;
    next_cycle();
    #1;
    $display("txn retire near wrap");
    check("cnt_ffff", retire_cnt, 32'hFFFF_FFFF);
    next_cycle();
    #1;
    check("cnt_wrap", retire_cnt, 32'h0);
    flush = 1;
    next_cycle();
    idle_inputs();
    #1;
    check("cnt_flush_hold", retire_cnt, 32'h0);
    wb_en_wb = 1;
    next_cycle();
    idle_inputs();
    #1;
    check("cnt_inc", retire_cnt, 32'h1);

    // Asynchronous reset between edges, held across an edge with a pending commit.
    wb_en_hilo_i = 1; wb_hi_i = 32'hAA; wb_lo_i = 32'hBB;
    next_cycle();
    idle_inputs();
    #1;
    check("pre_rst_hi", hi_o, 32'hAA);
    #1;
    rst_n = 1'b0;
    #1;
    $display("txn async reset mid-cycle");
    check("async_rst_hi", hi_o, 32'h0);
    check("async_rst_lo", lo_o, 32'h0);
    check("async_rst_cnt", retire_cnt, 32'h0);
    wb_en_hilo_i = 1; wb_hi_i = 32'hCC; wb_lo_i = 32'hDD; wb_en_wb = 1;
    next_cycle();
    wb_en_hilo_i = 0; wb_en_wb = 0;
    #1;
    check("rst_discard_hi", hi_o, 32'h0);
    check("rst_discard_cnt", retire_cnt, 32'h0);
    rst_n = 1'b1;
    wb_en_hilo_i = 1; wb_hi_i = 32'h5; wb_lo_i = 32'h6;
    next_cycle();
    idle_inputs();
    #1;
    check("first_commit_hi", hi_o, 32'h5);

    // Randomized traffic against the model.
    m_hi = 32'h5; m_lo = 32'h6; m_ll = 1'b0; m_cnt = 32'h0;
    for (int t = 0; t < 300; t++) begin
      next_cycle();
      wb_hi_i       = $urandom;
      wb_lo_i       = $urandom;
      mem_hi_i      = $urandom;
      mem_lo_i      = $urandom;
      wb_en_hilo_i  = ($urandom_range(0, 2) == 0);
      mem_en_hilo_i = ($urandom_range(0, 3) == 0);
      wb_LLbit_en   = ($urandom_range(0, 2) == 0);
      wb_LLbit_data = 1'($urandom_range(0, 1));
      wb_en_wb      = ($urandom_range(0, 1) == 1);
      flush         = ($urandom_range(0, 7) == 0);
      #1;
      if (mem_en_hilo_i) begin
        e_hi = mem_hi_i; e_lo = mem_lo_i;
      end else if (wb_en_hilo_i) begin
        e_hi = wb_hi_i; e_lo = wb_lo_i;
      end else begin
        e_hi = m_hi; e_lo = m_lo;
      end
      e_ll = flush ? 1'b0 : (wb_LLbit_en ? wb_LLbit_data : m_ll);
      $display("txn %0d hilo=%0b mem=%0b ll=%0b/%0b wb=%0b flush=%0b",
               t, wb_en_hilo_i, mem_en_hilo_i, wb_LLbit_en, wb_LLbit_data, wb_en_wb, flush);
      check("rnd_hi", hi_o, e_hi);
      check("rnd_lo", lo_o, e_lo);
      check("rnd_ll", {31'b0, LLbit_o}, {31'b0, e_ll});
      check("rnd_cnt", retire_cnt, m_cnt);
      if (wb_en_hilo_i) begin
        m_hi = wb_hi_i; m_lo = wb_lo_i;
      end
      m_ll = e_ll;
      if (wb_en_wb && !flush) m_cnt = m_cnt + 1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
